coeff_token_enc02: RTL and testbench

- CAVLC coeff_token encoder for the 0 <= nC < 2 VLC table. It is the transmit-side counterpart of the staged coeff_token decode LUTs.
- Accepts one (TotalCoeff, TrailingOnes) pair per handshake, looks up the codeword, and emits it serially, MSB first, on a valid/ready bit stream.
- Sits between the residual-block analyser and the bitstream packer in the CAVLC encode path.

---
 rtl/coeff_token_enc02.sv | 139 +++++++++++++
 tb/tb_coeff_token_enc02.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_token_enc02.sv
// CAVLC coeff_token encoder (0 <= nC < 2 table): one symbol in, codeword out serially MSB first.
// Optional emitted-bit counter on port BitCount when CT_ENC_BITCOUNT_EN is defined.
module coeff_token_enc02 #(
    parameter int CNT_WIDTH = 32
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       InValid,
    output logic       InReady,
    input  logic [4:0] TotalCoeff,
    input  logic [1:0] TrailingOnes,
    output logic       BitOut,
    output logic       BitValid,
    input  logic       BitReady,
    output logic       BitLast,
    output logic       Err
`ifdef CT_ENC_BITCOUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] BitCount
`endif
);

    // state | meaning
    // IDLE  | waiting for a symbol, no bit on the output
    // SHIFT | emitting codeword bits, Remaining counts bits still to go
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  remain_q, remain_d;
    logic        err_q, err_d;

    logic [20:0] lut;          // {length, right-aligned code}
    logic [15:0] code_aligned;
    logic        legal, fire, accept;

    always_comb begin
        lut = '0;
        case ({TotalCoeff, TrailingOnes})
            {5'd0, 2'd0}:  lut = {5'd1, 16'd1};
            {5'd1, 2'd0}:  lut = {5'd6, 16'd5};    {5'd1, 2'd1}:  lut = {5'd2, 16'd1};
            {5'd2, 2'd0}:  lut = {5'd8, 16'd7};    {5'd2, 2'd1}:  lut = {5'd6, 16'd4};
            {5'd2, 2'd2}:  lut = {5'd3, 16'd1};
            {5'd3, 2'd0}:  lut = {5'd9, 16'd7};    {5'd3, 2'd1}:  lut = {5'd8, 16'd6};
            {5'd3, 2'd2}:  lut = {5'd7, 16'd5};    {5'd3, 2'd3}:  lut = {5'd5, 16'd3};
            {5'd4, 2'd0}:  lut = {5'd10, 16'd7};   {5'd4, 2'd1}:  lut = {5'd9, 16'd6};
            {5'd4, 2'd2}:  lut = {5'd8, 16'd5};    {5'd4, 2'd3}:  lut = {5'd6, 16'd3};
            {5'd5, 2'd0}:  lut = {5'd11, 16'd7};   {5'd5, 2'd1}:  lut = {5'd10, 16'd6};
            {5'd5, 2'd2}:  lut = {5'd9, 16'd5};    {5'd5, 2'd3}:  lut = {5'd7, 16'd4};
            {5'd6, 2'd0}:  lut = {5'd13, 16'd15};  {5'd6, 2'd1}:  lut = {5'd11, 16'd6};
            {5'd6, 2'd2}:  lut = {5'd10, 16'd5};   {5'd6, 2'd3}:  lut = {5'd8, 16'd4};
            {5'd7, 2'd0}:  lut = {5'd13, 16'd11};  {5'd7, 2'd1}:  lut = {5'd13, 16'd14};
            {5'd7, 2'd2}:  lut = {5'd11, 16'd5};   {5'd7, 2'd3}:  lut = {5'd9, 16'd4};
            {5'd8, 2'd0}:  lut = {5'd13, 16'd8};   {5'd8, 2'd1}:  lut = {5'd13, 16'd10};
            {5'd8, 2'd2}:  lut = {5'd13, 16'd13};  {5'd8, 2'd3}:  lut = {5'd10, 16'd4};
            {5'd9, 2'd0}:  lut = {5'd14, 16'd15};  {5'd9, 2'd1}:  lut = {5'd14, 16'd14};
            {5'd9, 2'd2}:  lut = {5'd13, 16'd9};   {5'd9, 2'd3}:  lut = {5'd11, 16'd4};
            {5'd10, 2'd0}: lut = {5'd14, 16'd11};  {5'd10, 2'd1}: lut = {5'd14, 16'd10};
            {5'd10, 2'd2}: lut = {5'd14, 16'd13};  {5'd10, 2'd3}: lut = {5'd13, 16'd12};
            {5'd11, 2'd0}: lut = {5'd15, 16'd15};  {5'd11, 2'd1}: lut = {5'd15, 16'd14};
            {5'd11, 2'd2}: lut = {5'd14, 16'd9};   {5'd11, 2'd3}: lut = {5'd14, 16'd12};
            {5'd12, 2'd0}: lut = {5'd15, 16'd11};  {5'd12, 2'd1}: lut = {5'd15, 16'd10};
            {5'd12, 2'd2}: lut = {5'd15, 16'd13};  {5'd12, 2'd3}: lut = {5'd14, 16'd8};
            {5'd13, 2'd0}: lut = {5'd16, 16'd15};  {5'd13, 2'd1}: lut = {5'd15, 16'd1};
            {5'd13, 2'd2}: lut = {5'd15, 16'd9};   {5'd13, 2'd3}: lut = {5'd15, 16'd12};
            {5'd14, 2'd0}: lut = {5'd16, 16'd11};  {5'd14, 2'd1}: lut = {5'd16, 16'd14};
            {5'd14, 2'd2}: lut = {5'd16, 16'd13};  {5'd14, 2'd3}: lut = {5'd15, 16'd8};
            {5'd15, 2'd0}: lut = {5'd16, 16'd7};   {5'd15, 2'd1}: lut = {5'd16, 16'd10};
            {5'd15, 2'd2}: lut = {5'd16, 16'd9};   {5'd15, 2'd3}: lut = {5'd16, 16'd12};
            {5'd16, 2'd0}: lut = {5'd16, 16'd4};   {5'd16, 2'd1}: lut = {5'd16, 16'd6};
            {5'd16, 2'd2}: lut = {5'd16, 16'd5};   {5'd16, 2'd3}: lut = {5'd16, 16'd8};
            default:       lut = '0;
        endcase
    end

    // Left-align so the MSB of the codeword sits at shift_q[15]
    assign code_aligned = lut[15:0] << (5'd16 - lut[20:16]);
    assign legal        = (TotalCoeff <= 5'd16) && ({3'b000, TrailingOnes} <= TotalCoeff);

    assign BitValid = (state_q == SHIFT);
    assign BitOut   = shift_q[15];
    assign BitLast  = (state_q == SHIFT) && (remain_q == 5'd1);
    assign Err      = err_q;
    assign fire     = BitValid && BitReady;
    assign InReady  = Rst_n && ((state_q == IDLE) || (BitLast && BitReady));
    assign accept   = InValid && InReady;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        remain_d = remain_q;
        err_d    = 1'b0;
        if (fire) begin
            shift_d  = {shift_q[14:0], 1'b0};
            remain_d = remain_q - 5'd1;
            if (BitLast) begin
                state_d = IDLE;
            end
        end
        if (accept) begin
            if (legal) begin
                shift_d  = code_aligned;
                remain_d = lut[20:16];
                state_d  = SHIFT;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            remain_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            remain_q <= remain_d;
            err_q    <= err_d;
        end
    end

`ifdef CT_ENC_BITCOUNT_EN
    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count_q <= '0;
        end else if (fire) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign BitCount = count_q;
`endif

endmodule

// File: tb/tb_coeff_token_enc02.sv
// Self-checking bench for coeff_token_enc02: directed vector table, hand-written corner
// sequences, full round trip of all legal symbols and randomized traffic against a queue model.
module tb_coeff_token_enc02;

    logic       Clk = 1'b0;
    logic       Rst_n, InValid, BitReady;
    logic [4:0] TotalCoeff;
    logic [1:0] TrailingOnes;
    logic       InReady, BitOut, BitValid, BitLast, Err;
`ifdef CT_ENC_BITCOUNT_EN
    logic [31:0] BitCount;
`endif

    coeff_token_enc02 #(.CNT_WIDTH(32)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .InValid      (InValid),
        .InReady      (InReady),
        .TotalCoeff   (TotalCoeff),
        .TrailingOnes (TrailingOnes),
        .BitOut       (BitOut),
        .BitValid     (BitValid),
        .BitReady     (BitReady),
        .BitLast      (BitLast),
        .Err          (Err)
`ifdef CT_ENC_BITCOUNT_EN
        ,
        .BitCount     (BitCount)
`endif
    );

    always #5 Clk = ~Clk;

    int    n_cmp = 0;
    int    n_err = 0;
    string cw [0:16][0:3];

    // reference model state
    bit          m_cur[$];
    int          exp_syms[$];
    bit          m_err = 1'b0;
    logic [31:0] m_cnt = '0;

    string got_bits = "";
    string last_word = "";
    string stream = "";
    bit    err_seen = 1'b0;
    bit    last_acc = 1'b0;
    int    cyc = 0;
    int    first_bit_cyc = -1;
    int    last_bit_cyc = -1;
    int    n_words = 0;

    typedef struct {
        int    tc;
        int    t1;
        string code;
        bit    err;
    } vec_t;
    vec_t vecs[10];

    task automatic init_table();
        cw[0][0] = "1";
        cw[1][0] = "000101";    cw[1][1] = "01";
        cw[2][0] = "00000111";  cw[2][1] = "000100";    cw[2][2] = "001";
        cw[3][0] = "000000111"; cw[3][1] = "00000110";  cw[3][2] = "0000101"; cw[3][3] = "00011";
        cw[4][0] = "0000000111";       cw[4][1] = "000000110";        cw[4][2] = "00000101";         cw[4][3] = "000011";
        cw[5][0] = "00000000111";      cw[5][1] = "0000000110";       cw[5][2] = "000000101";        cw[5][3] = "0000100";
        cw[6][0] = "0000000001111";    cw[6][1] = "00000000110";      cw[6][2] = "0000000101";       cw[6][3] = "00000100";
        cw[7][0] = "0000000001011";    cw[7][1] = "0000000001110";    cw[7][2] = "00000000101";      cw[7][3] = "000000100";
        cw[8][0] = "0000000001000";    cw[8][1] = "0000000001010";    cw[8][2] = "0000000001101";    cw[8][3] = "0000000100";
        cw[9][0] = "00000000001111";   cw[9][1] = "00000000001110";   cw[9][2] = "0000000001001";    cw[9][3] = "00000000100";
        cw[10][0] = "00000000001011";  cw[10][1] = "00000000001010";  cw[10][2] = "00000000001101";  cw[10][3] = "0000000001100";
        cw[11][0] = "000000000001111"; cw[11][1] = "000000000001110"; cw[11][2] = "00000000001001";  cw[11][3] = "00000000001100";
        cw[12][0] = "000000000001011"; cw[12][1] = "000000000001010"; cw[12][2] = "000000000001101"; cw[12][3] = "00000000001000";
        cw[13][0] = "0000000000001111"; cw[13][1] = "000000000000001";  cw[13][2] = "000000000001001";  cw[13][3] = "000000000001100";
        cw[14][0] = "0000000000001011"; cw[14][1] = "0000000000001110"; cw[14][2] = "0000000000001101"; cw[14][3] = "000000000001000";
        cw[15][0] = "0000000000000111"; cw[15][1] = "0000000000001010"; cw[15][2] = "0000000000001001"; cw[15][3] = "0000000000001100";
        cw[16][0] = "0000000000000100"; cw[16][1] = "0000000000000110"; cw[16][2] = "0000000000000101"; cw[16][3] = "0000000000001000";
    endtask

    function automatic bit is_legal(input int tc, input int t1);
        return (tc <= 16) && (t1 <= tc);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string nm, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got \"%s\", expected \"%s\" (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Decode the collected bits by exact match against the code table (the code is prefix-free).
    task automatic check_word();
        int s, dtc, dt1;
        dtc = -1;
        dt1 = -1;
        for (int tc = 0; tc <= 16; tc++)
            for (int t1 = 0; t1 <= 3; t1++)
                if (is_legal(tc, t1) && cw[tc][t1] == got_bits) begin
                    dtc = tc;
                    dt1 = t1;
                end
        if (exp_syms.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL word_unexpected: got codeword \"%s\", expected no codeword", got_bits);
        end else begin
            s = exp_syms.pop_front();
            chk("rt_tc", dtc, s / 4);
            chk("rt_t1", dt1, s % 4);
            chk("rt_len", got_bits.len(), cw[s / 4][s % 4].len());
        end
        n_words++;
        last_word = got_bits;
        got_bits = "";
    endtask

    task automatic cycle(input logic iv, input logic [4:0] tc, input logic [1:0] t1,
                         input logic br, input logic rst);
        bit    exp_ready, exp_valid, fire, nerr;
        string bs, code;
        InValid      = iv;
        TotalCoeff   = tc;
        TrailingOnes = t1;
        BitReady     = br;
        Rst_n        = rst;
        #1;
        exp_valid = (m_cur.size() > 0);
        exp_ready = rst && (m_cur.size() == 0 || (m_cur.size() == 1 && br));
        fire      = exp_valid && br && rst;
        chk("InReady", InReady, exp_ready);
        chk("BitValid", BitValid, exp_valid);
        chk("BitOut", BitOut, exp_valid ? m_cur[0] : 1'b0);
        chk("BitLast", BitLast, m_cur.size() == 1);
        chk("Err", Err, m_err);
`ifdef CT_ENC_BITCOUNT_EN
        chk("BitCount", BitCount, m_cnt);
`endif
        if (Err === 1'b1) err_seen = 1'b1;
        last_acc = iv && exp_ready;
        if (rst && BitValid === 1'b1 && br) begin
            bs = (BitOut === 1'b1) ? "1" : "0";
            got_bits = {got_bits, bs};
            stream = {stream, bs};
            if (first_bit_cyc < 0) first_bit_cyc = cyc;
            last_bit_cyc = cyc;
            if (BitLast === 1'b1) check_word();
        end
        @(posedge Clk);
        #1;
        cyc++;
        if (!rst) begin
            m_cur.delete();
            exp_syms.delete();
            m_err = 1'b0;
            m_cnt = '0;
            got_bits = "";
        end else begin
            nerr = 1'b0;
            if (fire) begin
                void'(m_cur.pop_front());
                m_cnt = m_cnt + 1;
            end
            if (iv && exp_ready) begin
                if (is_legal(int'(tc), int'(t1))) begin
                    code = cw[tc][t1];
                    for (int i = 0; i < code.len(); i++) m_cur.push_back(code[i] == 8'h31);
                    exp_syms.push_back(int'(tc) * 4 + int'(t1));
                end else begin
                    nerr = 1'b1;
                end
            end
            m_err = nerr;
        end
    endtask

    task automatic send_sym(input int tc, input int t1, input logic br);
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, 5'(tc), 2'(t1), br, 1'b1);
            if (last_acc) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: InReady never high for (%0d,%0d), expected accept within 60 cycles", tc, t1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (m_cur.size() == 0 && !m_err) return;
            cycle(1'b0, 5'd0, 2'd0, 1'b1, 1'b1);
        end
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: encoder still busy, expected idle within 60 cycles");
    endtask

    initial begin
        logic br_pat[8];
        bit   r_iv;
        int   r_tc, r_t1, words0;
        logic r_br, r_rst;

        init_table();
        vecs[0] = '{0, 0, "1", 1'b0};
        vecs[1] = '{1, 1, "01", 1'b0};
        vecs[2] = '{1, 0, "000101", 1'b0};
        vecs[3] = '{16, 3, "0000000000001000", 1'b0};
        vecs[4] = '{2, 2, "001", 1'b0};
        vecs[5] = '{3, 3, "00011", 1'b0};
        vecs[6] = '{4, 3, "000011", 1'b0};
        vecs[7] = '{2, 3, "", 1'b1};
        vecs[8] = '{17, 0, "", 1'b1};
        vecs[9] = '{0, 1, "", 1'b1};

        Rst_n = 1'b0;
        InValid = 1'b0;
        TotalCoeff = '0;
        TrailingOnes = '0;
        BitReady = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        cycle(1'b1, 5'd0, 2'd0, 1'b1, 1'b0);   // inputs ignored while held in reset

        foreach (vecs[k]) begin
            last_word = "";
            err_seen = 1'b0;
            send_sym(vecs[k].tc, vecs[k].t1, 1'b1);
            drain();
            chk_str("vec_code", last_word, vecs[k].code);
            chk("vec_err", err_seen, vecs[k].err);
        end

        // back-to-back: second symbol waits on InValid and streams with no gap
        stream = "";
        first_bit_cyc = -1;
        send_sym(1, 1, 1'b1);
        send_sym(2, 2, 1'b1);
        drain();
        chk_str("b2b_stream", stream, "01001");
        chk("b2b_span", last_bit_cyc - first_bit_cyc, 4);

        // backpressure
        br_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        last_word = "";
        send_sym(3, 3, 1'b1);
        foreach (br_pat[k]) cycle(1'b0, 5'd0, 2'd0, br_pat[k], 1'b1);
        drain();
        chk_str("bp_code", last_word, "00011");

        // reset mid-codeword
        last_word = "";
        send_sym(16, 3, 1'b1);
        repeat (5) cycle(1'b0, 5'd0, 2'd0, 1'b1, 1'b1);
        cycle(1'b0, 5'd0, 2'd0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 5'd0, 2'd0, 1'b1, 1'b1);
        chk_str("rst_no_word", last_word, "");
        send_sym(0, 0, 1'b1);
        drain();
        chk_str("rst_recover", last_word, "1");

        // round trip of every legal symbol, streamed back to back
        words0 = n_words;
        for (int tc = 0; tc <= 16; tc++)
            for (int t1 = 0; t1 <= 3; t1++)
                if (is_legal(tc, t1)) send_sym(tc, t1, 1'b1);
        drain();
        chk("rt_words", n_words - words0, 62);

        // randomized traffic; upstream holds a symbol until it is taken
        r_iv = 1'b0;
        r_tc = 0;
        r_t1 = 0;
        last_acc = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!r_iv || last_acc || !r_rst) begin
                r_iv = ($urandom_range(0, 2) != 0);
                r_tc = (($urandom_range(0, 9) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16));
                r_t1 = $urandom_range(0, 3);
            end
            r_br  = ($urandom_range(0, 3) != 0);
            r_rst = ($urandom_range(0, 299) != 0);
            cycle(r_iv, 5'(r_tc), 2'(r_t1), r_br, r_rst);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 2 ms");
        $fatal(1, "time limit reached");
    end

endmodule
